// File: rtl/core_seq_pkg.sv
// Shared types and encodings for the core_seq attention-array sequencer.
// The SUM state exists only when CORE_SEQ_ABS_SUM_EN is defined.
package core_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KLOAD = 3'd1,
        QEXEC = 3'd2,
        DRAIN = 3'd3,
`ifdef CORE_SEQ_ABS_SUM_EN
        SUM   = 3'd4,
`endif
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] MI_IDLE  = 2'b00;
    localparam logic [1:0] MI_KLOAD = 2'b01;
    localparam logic [1:0] MI_EXEC  = 2'b10;

    localparam int BW_DEF = 32'sd8;

    // Psum lanes carry a full BW x BW product plus four guard bits for accumulation.
    function automatic int psum_width(input int bw);
        return (bw <<< 1) + 32'sd4;
    endfunction

    localparam int BW_PSUM_DEF = psum_width(BW_DEF);

endpackage

// File: rtl/psum_abs_sum.sv
// Registered sum of |psum| across COL signed lanes of one psum row (one cycle latency).
module psum_abs_sum
    import core_seq_pkg::*;
#(
    parameter int COL     = 8,
    parameter int BW_PSUM = BW_PSUM_DEF
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [COL*BW_PSUM-1:0]   psum,
    output logic [BW_PSUM+3:0]       sum_out,
    output logic                     sum_valid
);

    // Two's-complement negate; the most negative code maps to 2^(BW_PSUM-1) read as unsigned.
    function automatic logic [BW_PSUM-1:0] abs_mag(input logic [BW_PSUM-1:0] x);
        return x[BW_PSUM-1] ? (~x + {{(BW_PSUM-1){1'b0}}, 1'b1}) : x;
    endfunction

    logic [BW_PSUM+3:0] sum_s;
    logic [BW_PSUM+3:0] sum_r;
    logic               sum_valid_r;

    // Combinational adder tree over the lane magnitudes.
    always_comb begin
        sum_s = {(BW_PSUM+4){1'b0}};
        for (int i = 0; i < COL; i++) begin
            sum_s = sum_s + {4'b0000, abs_mag(psum[i*BW_PSUM +: BW_PSUM])};
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_r       <= {(BW_PSUM+4){1'b0}};
            sum_valid_r <= 1'b0;
        end else begin
            sum_valid_r <= in_valid;
            if (in_valid) begin
                sum_r <= sum_s;
            end
        end
    end

    assign sum_out   = sum_r;
    assign sum_valid = sum_valid_r;

endmodule

// File: rtl/core_seq.sv
// Job sequencer for the MAC array: K load, Q execute, output drain to psum memory,
// and an optional per-row |psum| sum pass compiled in with CORE_SEQ_ABS_SUM_EN.
module core_seq
    import core_seq_pkg::*;
#(
    parameter int COL      = 8,
    parameter int BW       = BW_DEF,
    parameter int BW_PSUM  = psum_width(BW),
    parameter int QK_DEPTH = 16,
    parameter int P_DEPTH  = 16,
    localparam int QK_AW   = $clog2(QK_DEPTH),
    localparam int P_AW    = $clog2(P_DEPTH)
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [QK_AW:0]          n_k,
    input  logic [QK_AW:0]          n_q,
    input  logic                    fifo_valid,
    input  logic [COL*BW_PSUM-1:0]  pmem_q,
    output logic                    qmem_rd,
    output logic                    kmem_rd,
    output logic                    pmem_rd,
    output logic                    pmem_wr,
    output logic                    ofifo_rd,
    output logic [QK_AW-1:0]        qk_addr,
    output logic [P_AW-1:0]         pmem_addr,
    output logic [1:0]              mac_inst,
    output logic [BW_PSUM+3:0]      sum_out,
    output logic                    sum_valid,
    output logic                    busy,
    output logic                    done
);

    // One shared row counter serves Q/K and psum addressing, so it spans the wider space.
    localparam int CW = ((QK_AW > P_AW) ? QK_AW : P_AW) + 1;
    localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] P_DEPTH_C = CW'(P_DEPTH);

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   n_k_r;
    logic [CW-1:0]   n_q_r;
    logic [CW-1:0]   last_k_s;
    logic [CW-1:0]   last_q_s;
    logic            kmem_rd_r;
    logic            qmem_rd_r;
    logic            busy_r;
    logic            done_r;
    logic [1:0]      mac_inst_r;
    logic            job_ok_s;
    logic            drain_go_s;
    logic            sum_valid_s;
    logic [BW_PSUM+3:0] sum_out_s;

    assign last_k_s   = n_k_r - ONE_C;
    assign last_q_s   = n_q_r - ONE_C;
    assign job_ok_s   = (n_k != {(QK_AW+1){1'b0}}) && (n_q != {(QK_AW+1){1'b0}})
                        && (CW'(n_q) <= P_DEPTH_C);
    // FIFO pops and psum writes follow fifo_valid in the same cycle to avoid over-reading.
    assign drain_go_s = (state_r == DRAIN) && fifo_valid;

`ifdef CORE_SEQ_ABS_SUM_EN
    logic          pmem_rd_r;
    logic          rd_d1_r;
    logic [CW-1:0] sum_cnt_r;

    // Align the read strobe with pmem_q, which returns one cycle after pmem_rd.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_d1_r <= 1'b0;
        end else begin
            rd_d1_r <= pmem_rd_r;
        end
    end

    psum_abs_sum #(
        .COL     (COL),
        .BW_PSUM (BW_PSUM)
    ) u_abs_sum (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_d1_r),
        .psum      (pmem_q),
        .sum_out   (sum_out_s),
        .sum_valid (sum_valid_s)
    );

    assign pmem_rd = pmem_rd_r;
`else
    logic pmem_q_unused_s;

    assign pmem_q_unused_s = ^pmem_q;
    assign sum_out_s       = {(BW_PSUM+4){1'b0}};
    assign sum_valid_s     = 1'b0;
    assign pmem_rd         = 1'b0;
`endif

    // Main job FSM with registered strobes, mac_inst, busy and done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            n_k_r      <= {CW{1'b0}};
            n_q_r      <= {CW{1'b0}};
            kmem_rd_r  <= 1'b0;
            qmem_rd_r  <= 1'b0;
            mac_inst_r <= MI_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef CORE_SEQ_ABS_SUM_EN
            pmem_rd_r  <= 1'b0;
            sum_cnt_r  <= {CW{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            // Array command trails the memory read by the memory's one-cycle latency.
            if (kmem_rd_r) begin
                mac_inst_r <= MI_KLOAD;
            end else if (qmem_rd_r) begin
                mac_inst_r <= MI_EXEC;
            end else begin
                mac_inst_r <= MI_IDLE;
            end

            case (state_r)
                IDLE: begin
                    if (start && job_ok_s) begin
                        state_r   <= KLOAD;
                        n_k_r     <= CW'(n_k);
                        n_q_r     <= CW'(n_q);
                        cnt_r     <= {CW{1'b0}};
                        kmem_rd_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end
                end
                KLOAD: begin
                    if (cnt_r == last_k_s) begin
                        state_r   <= QEXEC;
                        kmem_rd_r <= 1'b0;
                        qmem_rd_r <= 1'b1;
                        cnt_r     <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + ONE_C;
                    end
                end
                QEXEC: begin
                    if (cnt_r == last_q_s) begin
                        state_r   <= DRAIN;
                        qmem_rd_r <= 1'b0;
                        cnt_r     <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + ONE_C;
                    end
                end
                DRAIN: begin
                    if (fifo_valid) begin
                        if (cnt_r == last_q_s) begin
`ifdef CORE_SEQ_ABS_SUM_EN
                            state_r   <= SUM;
                            pmem_rd_r <= 1'b1;
                            cnt_r     <= {CW{1'b0}};
                            sum_cnt_r <= {CW{1'b0}};
`else
                            state_r   <= DONE;
                            done_r    <= 1'b1;
`endif
                        end else begin
                            cnt_r <= cnt_r + ONE_C;
                        end
                    end
                end
`ifdef CORE_SEQ_ABS_SUM_EN
                SUM: begin
                    if (pmem_rd_r) begin
                        if (cnt_r == last_q_s) begin
                            pmem_rd_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + ONE_C;
                        end
                    end
                    // Finish only once the row sum for the last address has emerged.
                    if (sum_valid_s) begin
                        if (sum_cnt_r == last_q_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            sum_cnt_r <= sum_cnt_r + ONE_C;
                        end
                    end
                end
`endif
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    kmem_rd_r <= 1'b0;
                    qmem_rd_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign kmem_rd   = kmem_rd_r;
    assign qmem_rd   = qmem_rd_r;
    assign ofifo_rd  = drain_go_s;
    assign pmem_wr   = drain_go_s;
    assign qk_addr   = cnt_r[QK_AW-1:0];
    assign pmem_addr = cnt_r[P_AW-1:0];
    assign mac_inst  = mac_inst_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign sum_out   = sum_out_s;
    assign sum_valid = sum_valid_s;

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter COL, default 8, number of MAC columns / psum lanes.
REQ-002 Parameter BW, default 8, activation/weight bit width.
REQ-003 Parameter BW_PSUM, default 2*BW+4, signed psum width per lane.
REQ-004 Parameter QK_DEPTH, default 16, Q/K memory rows; QK_AW = clog2(QK_DEPTH).
REQ-005 Parameter P_DEPTH, default 16, psum memory rows; P_AW = clog2(P_DEPTH).
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 start  in  1  one-cycle request to run a full job; sampled only in IDLE.
REQ-009 n_k  in  QK_AW+1  number of K rows to load (1..QK_DEPTH).
REQ-010 n_q  in  QK_AW+1  number of Q rows to execute (1..min(QK_DEPTH,P_DEPTH)).
REQ-011 fifo_valid  in  1  output FIFO holds a complete row.
REQ-012 pmem_q  in  COL*BW_PSUM  psum memory read data, valid one cycle after pmem_rd.
REQ-013 qmem_rd, kmem_rd, pmem_rd, pmem_wr, ofifo_rd  out  1 each  memory/FIFO strobes.
REQ-014 qk_addr  out  QK_AW  Q/K memory address; pmem_addr  out  P_AW  psum memory address.
REQ-015 mac_inst  out  2  array command: 2'b01 kernel load, 2'b10 execute, 2'b00 idle.
REQ-016 sum_out  out  BW_PSUM+4  unsigned sum of |psum| over COL lanes of one row.
REQ-017 sum_valid  out  1  sum_out valid this cycle; busy  out  1; done  out  1 (one-cycle pulse).

Function
REQ-018 FSM states SHALL be IDLE, KLOAD, QEXEC, DRAIN, SUM, DONE.
REQ-019 IDLE->KLOAD on start with n_k!=0, n_q!=0, n_q<=P_DEPTH; otherwise start SHALL be ignored.
REQ-020 KLOAD SHALL assert kmem_rd for n_k consecutive cycles, qk_addr 0..n_k-1.
REQ-021 mac_inst SHALL be 2'b01 exactly one cycle after each kmem_rd (memory read latency 1).
REQ-022 QEXEC SHALL assert qmem_rd for n_q consecutive cycles, qk_addr 0..n_q-1, mac_inst 2'b10 one cycle after each.
REQ-023 KLOAD->QEXEC and QEXEC->DRAIN SHALL occur on the cycle after the last read; no idle gap in reads.
REQ-024 DRAIN SHALL, each cycle fifo_valid=1, assert ofifo_rd and pmem_wr together, pmem_addr 0..n_q-1 ascending.
REQ-025 DRAIN SHALL stall (no strobes, address held) while fifo_valid=0; no timeout.
REQ-026 After n_q writes DRAIN->SUM (macro defined) or DRAIN->DONE (undefined).
REQ-027 SUM SHALL assert pmem_rd for n_q consecutive cycles, pmem_addr 0..n_q-1.
REQ-028 sum_out/sum_valid SHALL appear 2 cycles after the matching pmem_rd (1 read + 1 register stage), in address order.
REQ-029 |x| of the most negative BW_PSUM value SHALL be 2^(BW_PSUM-1); width BW_PSUM+4 makes overflow impossible for COL<=16.
REQ-030 SUM->DONE only after the last sum_valid; DONE lasts one cycle, pulses done, returns to IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-032 At most one of qmem_rd, kmem_rd, pmem_rd, pmem_wr SHALL be high in any cycle.
REQ-033 n_k, n_q SHALL be latched at start; later changes SHALL not affect the running job.

Reset
REQ-034 With reset=0 at a rising edge: state IDLE; all strobes, mac_inst, sum_out, sum_valid, busy, done SHALL be 0 from that edge.
REQ-035 Reset mid-job SHALL abort immediately; no partial strobes after the edge; pipeline stage cleared.

Configuration
REQ-036 Macro CORE_SEQ_ABS_SUM_EN defined: SUM state and abs-sum datapath compiled in.
REQ-037 Macro undefined: SUM state absent, pmem_rd tied 0, sum_out and sum_valid tied 0; all else identical.

Structure
REQ-038 Package core_seq_pkg SHALL hold the state enum, mac_inst encodings (MI_IDLE, MI_KLOAD, MI_EXEC) and BW_PSUM default.
REQ-039 Sub-module psum_abs_sum SHALL compute the registered COL-lane abs-sum (one cycle latency).

Verification
REQ-040 n_k=3,n_q=2, fifo_valid=1: kmem_rd addr 0,1,2; mac_inst 01 at next 3 cycles; qmem_rd addr 0,1; done after 2 writes + 2 sums.
REQ-041 fifo_valid toggled 1,0,0,1 in DRAIN, n_q=2: pmem_wr at cycles 1 and 4 only, addresses 0,1.
REQ-042 pmem_q lanes all 0x80000 (-2^19), COL=8: sum_out=0x400000, sum_valid 2 cycles after pmem_rd.
REQ-043 start with n_q=0, then start during KLOAD: both ignored; busy stays 0 / job unaffected.
REQ-044 reset=0 during QEXEC: next cycle all strobes 0, state IDLE; new start runs full job normally.
REQ-045 Macro undefined, n_k=1,n_q=1: DRAIN->DONE directly; pmem_rd, sum_valid never asserted.
